// File: rtl/adc_lcd_pkg.sv
// Shared types and defaults for the ADC-to-LCD capture path.
// State encoding, default sizes and the address-width helper.
package adc_lcd_pkg;

  typedef enum logic [2:0] {
    POR_WAIT,
    IDLE,
    ARMED,
    CAPTURE,
    HOLDOFF
  } cw_state_e;

  localparam int unsigned POR_CYCLES_DEF     = 400000;
  localparam int unsigned DEPTH_DEF          = 800;
  localparam int unsigned HOLDOFF_CYCLES_DEF = 1000;

  function automatic int unsigned addr_w_of(
    input int unsigned depth
  );
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser with a registered rising-edge pulse.
// A held-high input yields exactly one pulse.
module sync_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic pulse
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic pulse_q;
  logic pulse_d;

  // edge detect on the synchronised level
  always_comb begin
    pulse_d = sync_q & ~prev_q;
  end

  // synchroniser chain and pulse register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      meta_q  <= din;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      pulse_q <= pulse_d;
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/capture_window_ctrl.sv
// Sample-buffer write sequencer: power-on settle, then one
// frame-aligned window of DEPTH writes per capture request.
module capture_window_ctrl
  import adc_lcd_pkg::*;
#(
  parameter int unsigned POR_CYCLES     = POR_CYCLES_DEF,
  parameter int unsigned DEPTH          = DEPTH_DEF,
  parameter int unsigned ADDR_W         = addr_w_of(DEPTH),
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START_TR,
  input  logic              FRAME_SYNC,
  input  logic              SAMPLE_VALID,
  input  logic              MODE_FREERUN,
  output logic              READY,
  output logic              BUSY,
  output logic              BUF_WR_EN,
  output logic [ADDR_W-1:0] BUF_WR_ADDR,
  output logic              DONE
);

  localparam logic [31:0] POR_LAST = 32'(POR_CYCLES - 1);
  localparam logic [31:0] HOLD_N   = 32'(HOLDOFF_CYCLES);
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(DEPTH - 1);

  logic start_pls;

  cw_state_e         state_q, state_d;
  logic [31:0]       por_q, por_d;
  logic [31:0]       hold_q, hold_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic              done_q, done_d;

  sync_rise_det u_start_sync (
    .clk   (CLK),
    .rst_n (RESET_N),
    .din   (START_TR),
    .pulse (start_pls)
  );

  // next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    por_d   = por_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    wr_en_d = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      POR_WAIT: begin
        por_d = por_q + 32'd1;
        if (por_q == POR_LAST) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      IDLE: begin
        if (start_pls) begin
          state_d = ARMED;
          busy_d  = 1'b1;
        end
      end
      ARMED: begin
        if (FRAME_SYNC) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end
      end
      CAPTURE: begin
        if (SAMPLE_VALID) begin
          wr_en_d = 1'b1;
          addr_d  = cnt_q;
          if (cnt_q == CNT_LAST) begin
            done_d  = 1'b1;
            state_d = HOLDOFF;
            hold_d  = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      HOLDOFF: begin
        if (hold_q == HOLD_N) begin
          state_d = MODE_FREERUN ? ARMED : IDLE;
          busy_d  = MODE_FREERUN;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      default: begin
        state_d = POR_WAIT;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= POR_WAIT;
      por_q   <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      por_q   <= por_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      wr_en_q <= wr_en_d;
      done_q  <= done_d;
    end
  end

  assign READY       = ready_q;
  assign BUSY        = busy_q;
  assign BUF_WR_EN   = wr_en_q;
  assign BUF_WR_ADDR = addr_q;
  assign DONE        = done_q;

endmodule

// File: tb/tb_capture_window_ctrl.sv
// Directed bench for capture_window_ctrl.
// POR_CYCLES=16, DEPTH=8, HOLDOFF_CYCLES=4.
module tb_capture_window_ctrl;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       START_TR;
  logic       FRAME_SYNC;
  logic       SAMPLE_VALID;
  logic       MODE_FREERUN;
  logic       READY;
  logic       BUSY;
  logic       BUF_WR_EN;
  logic [2:0] BUF_WR_ADDR;
  logic       DONE;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int base_wr;
  int base_done;

  capture_window_ctrl #(
    .POR_CYCLES     (16),
    .DEPTH          (8),
    .ADDR_W         (3),
    .HOLDOFF_CYCLES (4)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .START_TR     (START_TR),
    .FRAME_SYNC   (FRAME_SYNC),
    .SAMPLE_VALID (SAMPLE_VALID),
    .MODE_FREERUN (MODE_FREERUN),
    .READY        (READY),
    .BUSY         (BUSY),
    .BUF_WR_EN    (BUF_WR_EN),
    .BUF_WR_ADDR  (BUF_WR_ADDR),
    .DONE         (DONE)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (BUF_WR_EN) wr_cnt <= wr_cnt + 1;
    if (DONE) done_cnt <= done_cnt + 1;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, 32'(READY), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_wren"}, 32'(BUF_WR_EN), 0);
    chk({tag, "_addr"}, 32'(BUF_WR_ADDR), 0);
    chk({tag, "_done"}, 32'(DONE), 0);
  endtask

  initial begin
    RESET_N      = 1'b0;
    START_TR     = 1'b0;
    FRAME_SYNC   = 1'b0;
    SAMPLE_VALID = 1'b0;
    MODE_FREERUN = 1'b0;
    tick();
    tick();
    chk_zero("rst");

    // power-on with an early start pulse
    RESET_N = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 5) START_TR = 1'b1;
      if (c == 6) START_TR = 1'b0;
      if (c == 15) chk("por_ready15", 32'(READY), 0);
      if (c == 16) chk("por_ready16", 32'(READY), 1);
    end
    chk("por_busy", 32'(BUSY), 0);

    // single capture, with overrun and mid-window noise
    base_wr = wr_cnt;
    base_done = done_cnt;
    START_TR = 1'b1;
    tick(); tick(); tick();
    chk("arm_busy3", 32'(BUSY), 0);
    tick();
    chk("arm_busy4", 32'(BUSY), 1);
    START_TR = 1'b0;
    FRAME_SYNC = 1'b1;
    tick();
    FRAME_SYNC = 1'b0;
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) START_TR = 1'b1;
      if (i == 3) FRAME_SYNC = 1'b1;
      tick();
      FRAME_SYNC = 1'b0;
      chk($sformatf("w1_en%0d", i), 32'(BUF_WR_EN), 1);
      chk($sformatf("w1_addr%0d", i), 32'(BUF_WR_ADDR), i);
      chk($sformatf("w1_done%0d", i), 32'(DONE), (i == 7));
    end
    START_TR = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      if (j == 4) SAMPLE_VALID = 1'b0;
      chk($sformatf("ovr_en%0d", j), 32'(BUF_WR_EN), 0);
      chk($sformatf("ovr_addr%0d", j), 32'(BUF_WR_ADDR), 7);
      chk($sformatf("hold_busy%0d", j), 32'(BUSY), (j < 5));
    end
    for (int j = 0; j < 8; j++) tick();
    chk("w1_busy_after", 32'(BUSY), 0);
    chk("w1_wr_total", 32'(wr_cnt - base_wr), 8);
    chk("w1_done_total", 32'(done_cnt - base_done), 1);

    // free-run: two windows, boundary strobe on the first
    base_wr = wr_cnt;
    base_done = done_cnt;
    MODE_FREERUN = 1'b1;
    START_TR = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    chk("fr_busy", 32'(BUSY), 1);
    START_TR = 1'b0;
    FRAME_SYNC = 1'b1;
    SAMPLE_VALID = 1'b1;
    tick();
    chk("bnd_en", 32'(BUF_WR_EN), 0);
    FRAME_SYNC = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("fr1_addr%0d", i), 32'(BUF_WR_ADDR), i);
      chk($sformatf("fr1_en%0d", i), 32'(BUF_WR_EN), 1);
    end
    chk("fr1_done", 32'(DONE), 1);
    SAMPLE_VALID = 1'b0;
    for (int j = 0; j < 7; j++) tick();
    chk("fr_rearm_busy", 32'(BUSY), 1);
    chk("fr_rearm_en", 32'(BUF_WR_EN), 0);
    FRAME_SYNC = 1'b1;
    tick();
    FRAME_SYNC = 1'b0;
    MODE_FREERUN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      SAMPLE_VALID = 1'b1;
      tick();
      SAMPLE_VALID = 1'b0;
      chk($sformatf("fr2_addr%0d", i), 32'(BUF_WR_ADDR), i);
      chk($sformatf("fr2_done%0d", i), 32'(DONE), (i == 7));
      tick();
      chk($sformatf("fr2_gap_en%0d", i), 32'(BUF_WR_EN), 0);
      chk($sformatf("fr2_gap_addr%0d", i), 32'(BUF_WR_ADDR), i);
    end
    for (int j = 0; j < 6; j++) tick();
    chk("fr_idle_busy", 32'(BUSY), 0);
    chk("fr_wr_total", 32'(wr_cnt - base_wr), 16);
    chk("fr_done_total", 32'(done_cnt - base_done), 2);

    // reset in the middle of a window
    base_done = done_cnt;
    START_TR = 1'b1;
    for (int j = 0; j < 4; j++) tick();
    START_TR = 1'b0;
    chk("mr_busy", 32'(BUSY), 1);
    FRAME_SYNC = 1'b1;
    tick();
    FRAME_SYNC = 1'b0;
    SAMPLE_VALID = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mr_addr3", 32'(BUF_WR_ADDR), 3);
    chk("mr_en3", 32'(BUF_WR_EN), 1);
    #2;
    RESET_N = 1'b0;
    #1;
    chk_zero("mr_async");
    SAMPLE_VALID = 1'b0;
    tick();
    RESET_N = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 15) chk("mr_ready15", 32'(READY), 0);
      if (c == 16) chk("mr_ready16", 32'(READY), 1);
    end
    chk("mr_busy_after", 32'(BUSY), 0);
    chk("mr_no_done", 32'(done_cnt - base_done), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/capture_window_ctrl.md
Name: capture_window_ctrl

Overview:
- Sequences the ADC-to-display sample buffer: holds writes off for a power-on settle period, then opens one write window of DEPTH samples per capture request.
- Each window is aligned to the display frame sync.
- Sits between the mic ADC sample strobe, the LCD timing generator and the sample buffer write port, and replaces ad-hoc toggle logic for buffer write on/off.

Parameters:
- POR_CYCLES, 400000, CLK cycles after reset release before the block reports READY.
- DEPTH, 800, samples written per capture window (one per display column).
- ADDR_W, 10, buffer address width; must satisfy 2^ADDR_W >= DEPTH.
- HOLDOFF_CYCLES, 1000, minimum idle cycles after a window before re-arming.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- START_TR  in  1  asynchronous capture request (key/external); synchronised internally.
- FRAME_SYNC  in  1  frame-start pulse from LCD timing, CLK domain, one cycle wide.
- SAMPLE_VALID  in  1  ADC sample strobe, CLK domain, one cycle per sample.
- MODE_FREERUN  in  1  1 = auto re-arm after each window; sampled only in HOLDOFF.
- READY  out  1  power-on delay elapsed; stays 1 until reset.
- BUSY  out  1  1 in ARMED, CAPTURE and HOLDOFF.
- BUF_WR_EN  out  1  buffer write strobe.
- BUF_WR_ADDR  out  ADDR_W  buffer write address.
- DONE  out  1  one-cycle pulse when the last sample of a window is written.

Behaviour:
- Reset (RESET_N low, async):
  - State POR_WAIT; all counters 0.
  - READY=0, BUSY=0, BUF_WR_EN=0, BUF_WR_ADDR=0, DONE=0.
  - Synchroniser flops cleared.
- Reset asserted mid-capture aborts immediately. No DONE is issued, and the partial buffer contents are not invalidated.
- START_TR synchronisation:
  - Two-flop synchroniser, then rising-edge detect.
  - Internal start pulse occurs 3 CLK edges after the START_TR rise; a level held high yields exactly one pulse.
- POR_WAIT:
  - 32-bit counter increments each cycle.
  - When it reaches POR_CYCLES-1, go to IDLE and set READY=1 on the next edge.
  - Start pulses during POR_WAIT are discarded, not queued.
- IDLE: start pulse -> ARMED; BUSY=1 from the next cycle.
- ARMED:
  - Wait for FRAME_SYNC; then -> CAPTURE and clear the sample counter.
  - SAMPLE_VALID in ARMED is ignored.
  - FRAME_SYNC and SAMPLE_VALID in the same cycle: the sample is not written; capture starts with the next strobe.
- CAPTURE:
  - Each SAMPLE_VALID produces, one cycle later (registered), BUF_WR_EN=1 for exactly one cycle with BUF_WR_ADDR=count; count then increments.
  - The write with count=DEPTH-1 asserts DONE in the same cycle as its BUF_WR_EN; state -> HOLDOFF.
  - Strobes arriving after the DEPTH-th are ignored. Count never wraps and the address never exceeds DEPTH-1.
  - FRAME_SYNC during CAPTURE is ignored; the window does not restart.
- HOLDOFF:
  - Counts HOLDOFF_CYCLES cycles, then -> ARMED if MODE_FREERUN=1, else -> IDLE (BUSY=0 next cycle).
- Start pulses in ARMED, CAPTURE or HOLDOFF are dropped; there is no request queue.
- BUF_WR_EN is 0 in every state except the registered write cycle in CAPTURE.
- BUF_WR_ADDR holds its last value between writes.
- Throughput: one write per SAMPLE_VALID; back-to-back strobes on consecutive cycles are supported.

Decomposition:
- Shared package adc_lcd_pkg:
  - state enumeration POR_WAIT/IDLE/ARMED/CAPTURE/HOLDOFF (3-bit);
  - default constants for POR_CYCLES, DEPTH, HOLDOFF_CYCLES;
  - ADDR_W derivation helper (clog2).
- One sub-module, sync_rise_det: 2-flop synchroniser plus rising-edge pulse, reset by RESET_N. Reusable for other key inputs.

Test Plan (POR_CYCLES=16, DEPTH=8, HOLDOFF_CYCLES=4 unless noted):
- Power-on: release RESET_N, pulse START_TR at cycle 5 -> READY rises at cycle 16; no ARMED entry; BUSY stays 0.
- Single capture:
  - after READY, raise START_TR -> BUSY=1 4 cycles later;
  - FRAME_SYNC, then 8 SAMPLE_VALID strobes on consecutive cycles -> 8 writes with addresses 0..7, each one cycle after its strobe;
  - DONE coincides with the address-7 write;
  - BUSY falls 4+1 cycles later.
- Overrun/ignore:
  - 12 strobes in CAPTURE -> exactly 8 writes;
  - a START_TR edge and an extra FRAME_SYNC mid-capture -> no restart, no second window.
- Free-run: MODE_FREERUN=1 -> after HOLDOFF re-enters ARMED; the next FRAME_SYNC starts a second window at address 0; DONE pulses twice total.
- Boundary: FRAME_SYNC and SAMPLE_VALID in the same cycle -> that sample is not written; first write is address 0 from the following strobe.
- Reset mid-capture: RESET_N low after the address-3 write -> all outputs 0 asynchronously, no DONE; after release, the POR_WAIT 16-cycle delay repeats before READY.
